// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the proc2mem/mem2proc tagged bus.
//
// Accepts at most one LOAD or STORE per cycle. Each accepted command gets a
// nonzero 4-bit tag, combinationally and in the same cycle. The tag runs
// 1..15 and wraps back to 1. A STORE writes the word-addressed 64-bit array
// at the closing clock edge. A LOAD snapshots the array word at acceptance
// and returns {tag, data} exactly LATENCY cycles later, for one cycle.
//
// Optional build macro: MEM_STALL_EN
//   When defined, every STALL_PERIOD-th LOAD/STORE presented is rejected
//   (response 0, no side effects) so that requester retry paths get
//   exercised.
//
// Ports:
//   clock              in   1   rising-edge clock
//   reset              in   1   asynchronous active-low reset
//   proc2mem_command   in   2   0 NONE, 1 LOAD, 2 STORE, 3 invalid
//   proc2mem_addr      in  64   byte address, bits [2:0] ignored
//   proc2mem_data      in  64   store data
//   mem2proc_response  out  4   accepted tag (comb), 0 = none/rejected
//   mem2proc_data      out 64   returning load data (registered)
//   mem2proc_tag       out  4   returning load tag (registered), 0 = none
module mem_responder #(
  parameter int unsigned MEM_WORDS    = 8192,
  parameter int unsigned LATENCY      = 4,
  parameter int unsigned STALL_PERIOD = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2mem_command,
  input  logic [63:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  output logic [3:0]  mem2proc_response,
  output logic [63:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    BUS_NONE    = 2'd0,
    BUS_LOAD    = 2'd1,
    BUS_STORE   = 2'd2,
    BUS_INVALID = 2'd3
  } bus_cmd_e;

  bus_cmd_e         cmd;
  logic [IDX_W-1:0] idx;
  logic [63:0]      rd_word;
  logic             is_cmd;
  logic             reject;
  logic             accept;
  logic             load_acc;
  logic             store_acc;

  logic [3:0]       tag_q, tag_d;
  logic [3:0]       pipe_tag_q  [LATENCY];
  logic [63:0]      pipe_data_q [LATENCY];

  logic [63:0]      mem [MEM_WORDS];

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{proc2mem_addr[63:3+IDX_W], proc2mem_addr[2:0]};

  assign cmd     = bus_cmd_e'(proc2mem_command);
  assign idx     = proc2mem_addr[3 +: IDX_W];
  assign rd_word = mem[idx];
  assign is_cmd  = (cmd == BUS_LOAD) || (cmd == BUS_STORE);

`ifdef MEM_STALL_EN
  localparam int unsigned STALL_W = $clog2(STALL_PERIOD);

  logic [STALL_W-1:0] stall_q, stall_d;

  // Counts every LOAD/STORE presented, accepted or not; the last slot of
  // each period is the rejected one.
  assign reject = is_cmd && (stall_q == STALL_W'(STALL_PERIOD - 1));

  always_comb begin
    stall_d = stall_q;
    if (is_cmd) begin
      stall_d = reject ? '0 : stall_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  localparam int unsigned unused_stall_period = STALL_PERIOD;

  assign reject = 1'b0;
`endif

  assign accept    = is_cmd && !reject;
  assign load_acc  = accept && (cmd == BUS_LOAD);
  assign store_acc = accept && (cmd == BUS_STORE);

  // Response is forced to 0 while reset is held, even if a command is
  // present on the bus.
  assign mem2proc_response = (accept && reset) ? tag_q : '0;

  always_comb begin
    tag_d = tag_q;
    if (accept) begin
      tag_d = (tag_q == 4'd15) ? 4'd1 : tag_q + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_q <= 4'd1;
    end else begin
      tag_q <= tag_d;
    end
  end

  // Return pipeline. A zero tag marks an empty slot. Empty slots carry zero
  // data, so the last stage can drive the outputs directly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_tag_q[i]  <= '0;
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_tag_q[0]  <= load_acc ? tag_q : '0;
      pipe_data_q[0] <= load_acc ? rd_word : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_tag_q[i]  <= pipe_tag_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  assign mem2proc_tag  = pipe_tag_q[LATENCY-1];
  assign mem2proc_data = pipe_data_q[LATENCY-1];

  // Storage is never reset, so its contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (store_acc) begin
      mem[idx] <= proc2mem_data;
    end
  end

endmodule
